// File: rtl/apb_csr_master_arb_pkg.sv
// Shared definitions for the APB CSR master: FSM state encoding and requester ids.
package apb_csr_master_arb_pkg;

  // APB transfer phases sequenced by the master
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Requester id encodings, also used as the grant / owner / last_grant value
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a sole requester wins, a tie goes to the
// requester that did not win last time. Purely combinational.
module rr_arb2
  import apb_csr_master_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  // Pick the winner from the current requests and the previous winner
  always_comb begin
    grant_valid = valid0 | valid1;
    grant       = REQ0;
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else if (valid1) begin
      grant = REQ1;
    end
  end

endmodule

// File: rtl/apb_csr_master_arb.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// bounded wait for slave ready, and a one-cycle done pulse to the owner.
module apb_csr_master_arb #(
  parameter int ADDRESS_SIZE   = 32,
  parameter int REG_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  input  logic                    req0_write,
  input  logic [ADDRESS_SIZE-1:0] req0_addr,
  input  logic [REG_WIDTH-1:0]    req0_wdata,
  output logic                    req0_ready,
  output logic                    req0_done,
  input  logic                    req1_valid,
  input  logic                    req1_write,
  input  logic [ADDRESS_SIZE-1:0] req1_addr,
  input  logic [REG_WIDTH-1:0]    req1_wdata,
  output logic                    req1_ready,
  output logic                    req1_done,
  output logic [REG_WIDTH-1:0]    rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDRESS_SIZE-1:0] addr,
  output logic                    sel,
  output logic                    en,
  output logic                    write,
  output logic [REG_WIDTH-1:0]    wdata,
  input  logic [REG_WIDTH-1:0]    rdata,
  input  logic                    ready,
  input  logic                    slv_err
);

  import apb_csr_master_arb_pkg::*;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic                 owner;
  logic                 last_grant;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 grant_valid;
  logic                 grant;

  rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Accept handshake is only offered in IDLE, and only to the winner
  always_comb begin
    req0_ready = (state == IDLE) && grant_valid && (grant == REQ0);
    req1_ready = (state == IDLE) && grant_valid && (grant == REQ1);
  end

  // Transfer FSM with registered APB, response and done outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= REQ0;
      last_grant <= REQ1;
      cnt        <= '0;
      sel        <= 1'b0;
      en         <= 1'b0;
      write      <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        IDLE: begin
          sel <= 1'b0;
          en  <= 1'b0;
          if (grant_valid) begin
            // Payload is latched once and held for the whole transfer
            owner <= grant;
            addr  <= (grant == REQ1) ? req1_addr  : req0_addr;
            write <= (grant == REQ1) ? req1_write : req0_write;
            wdata <= (grant == REQ1) ? req1_wdata : req0_wdata;
            sel   <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          en    <= 1'b1;
          cnt   <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (ready) begin
            rsp_rdata  <= write ? '0 : rdata;
            rsp_err    <= slv_err;
            req0_done  <= (owner == REQ0);
            req1_done  <= (owner == REQ1);
            last_grant <= owner;
            sel        <= 1'b0;
            en         <= 1'b0;
            state      <= IDLE;
          end else if (cnt == TIMEOUT_LAST) begin
            // Slave never answered: abort and report an error to the owner
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            req0_done <= (owner == REQ0);
            req1_done <= (owner == REQ1);
            sel       <= 1'b0;
            en        <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          sel   <= 1'b0;
          en    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
